// File: rtl/breakout_pkg.sv
// ---------------------------------------------------------------------------
// breakout_pkg
// Shared constants and types for the breakout ball pipeline: screen geometry,
// coordinate widths, ball-motion state encoding and the collision face bundle.
// No ports (package).
// ---------------------------------------------------------------------------
package breakout_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int BALL_SIZE = 5;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int STEP_W    = 2;   // per-frame step, 1..3

  // Ball-motion state encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    PLAY   = ST_PLAY,
    UPDATE = ST_UPDATE
  } state_t;

  // One bit per ball face; each bit independently flags a hit on that face.
  typedef struct packed {
    logic top;
    logic bottom;
    logic left;
    logic right;
  } hits_t;

endpackage

// File: rtl/ball_motion_collision_latch.sv
// ---------------------------------------------------------------------------
// collision_latch
// Four sticky hit flags. While acc_en is high, each face flag ORs in its
// painter edge flag qualified by the playfield solid pixel. clear (or rst)
// empties all flags on the next edge and has priority over accumulation.
// Ports:
//   clk, rst      pixel clock, synchronous active-high reset
//   acc_en        accumulate edge&solid into the flags this cycle
//   clear         drop all flags
//   edges         painter edge flags for the current pixel
//   solid         current pixel is an obstacle
//   hits          registered per-face hit flags
// ---------------------------------------------------------------------------
module collision_latch
  import breakout_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  acc_en,
  input  logic  clear,
  input  hits_t edges,
  input  logic  solid,
  output hits_t hits
);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hits <= '0;
    end else if (acc_en) begin
      hits <= hits | (edges & {4{solid}});
    end
  end

endmodule

// File: rtl/ball_motion.sv
// ---------------------------------------------------------------------------
// ball_motion
// Ball physics stage upstream of the sprite painter. Owns ball position and
// direction, gathers collision hits during active video, and once per frame
// reflects and steps the ball. Handles serve-from-rest and ball-lost.
//
// Ports:
//   clk, rst                pixel clock, synchronous active-high reset
//   frame_pulse             one-cycle strobe on the first vblank cycle
//   in_ball_top/bottom/left/right   painter collision edge flags
//   solid                   current pixel is wall/brick/paddle
//   launch                  serve request, only honoured at rest
//   x, y                    ball top-left column / row
//   dir_x, dir_y            1 = moving right / down
//   moving                  ball in play (PLAY or UPDATE)
//   lost                    one-cycle pulse when the ball falls past LOST_Y
//
// Build option: define BALL_SPEEDUP_EN to add a bounce counter that raises
// the per-frame step every 8 reflections (saturating at 3, back to STEP on
// loss/reset). Without it the step is fixed at STEP.
// ---------------------------------------------------------------------------
module ball_motion
  import breakout_pkg::*;
#(
  parameter logic [X_W-1:0] START_X = 10'd318,
  parameter logic [Y_W-1:0] START_Y = 9'd300,
  parameter logic [X_W-1:0] X_MIN   = 10'd8,
  parameter logic [X_W-1:0] X_MAX   = 10'd627,
  parameter logic [Y_W-1:0] Y_MIN   = 9'd8,
  parameter logic [Y_W-1:0] LOST_Y  = 9'd475,
  parameter int             STEP    = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_pulse,
  input  logic           in_ball_top,
  input  logic           in_ball_bottom,
  input  logic           in_ball_left,
  input  logic           in_ball_right,
  input  logic           solid,
  input  logic           launch,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           dir_x,
  output logic           dir_y,
  output logic           moving,
  output logic           lost
);

  state_t              state;
  hits_t               hits;
  hits_t               edges;
  logic [STEP_W-1:0]   step;

  logic                nd_x, nd_y;
  logic                refl_x, refl_y;
  logic [X_W-1:0]      nx;
  logic [Y_W-1:0]      ny;
  logic                lost_next;

  assign edges = '{top: in_ball_top, bottom: in_ball_bottom,
                   left: in_ball_left, right: in_ball_right};

  // Flags only grow during PLAY; UPDATE consumes and empties them, and at
  // rest they stay empty.
  collision_latch u_latch (
    .clk    (clk),
    .rst    (rst),
    .acc_en (state == PLAY),
    .clear  (state != PLAY),
    .edges  (edges),
    .solid  (solid),
    .hits   (hits)
  );

  // Next direction/position, consumed only in UPDATE.
  // NOTE: every output of this block gets a default first so no latch is
  // inferred on paths that skip an assignment.
  always_comb begin
    nd_x   = dir_x;
    nd_y   = dir_y;
    refl_x = 1'b0;
    refl_y = 1'b0;

    // A hit only reflects when the ball travels into that face.
    if (hits.left && !dir_x) begin
      nd_x   = 1'b1;
      refl_x = 1'b1;
    end else if (hits.right && dir_x) begin
      nd_x   = 1'b0;
      refl_x = 1'b1;
    end
    if (hits.top && !dir_y) begin
      nd_y   = 1'b1;
      refl_y = 1'b1;
    end else if (hits.bottom && dir_y) begin
      nd_y   = 1'b0;
      refl_y = 1'b1;
    end

    // Hard bounds override hits so the ball can never leave the playfield.
    if (x <= X_MIN)      nd_x = 1'b1;
    else if (x >= X_MAX) nd_x = 1'b0;
    if (y <= Y_MIN)      nd_y = 1'b1;

    nx = nd_x ? x + X_W'(step) : x - X_W'(step);
    ny = nd_y ? y + Y_W'(step) : y - Y_W'(step);
    lost_next = (ny >= LOST_Y);
  end

  // Main FSM with registered outputs. Reset is synchronous: nothing here
  // changes until the next clk edge after rst rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      x      <= START_X;
      y      <= START_Y;
      dir_x  <= 1'b1;
      dir_y  <= 1'b0;
      moving <= 1'b0;
      lost   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          lost <= 1'b0;
          x    <= START_X;
          y    <= START_Y;
          if (launch) begin
            state  <= PLAY;
            moving <= 1'b1;
          end
        end
        PLAY: begin
          lost <= 1'b0;
          if (frame_pulse) state <= UPDATE;
        end
        UPDATE: begin
          if (lost_next) begin
            state  <= IDLE;
            lost   <= 1'b1;
            moving <= 1'b0;
            x      <= START_X;
            y      <= START_Y;
            dir_x  <= 1'b1;
            dir_y  <= 1'b0;
          end else begin
            state <= PLAY;
            x     <= nx;
            y     <= ny;
            dir_x <= nd_x;
            dir_y <= nd_y;
          end
        end
        default: begin
          state  <= IDLE;
          moving <= 1'b0;
          lost   <= 1'b0;
        end
      endcase
    end
  end

`ifdef BALL_SPEEDUP_EN
  logic [2:0] bounce_cnt;
  logic [3:0] bounce_sum;

  // Carry out of the 3-bit counter marks another 8 reflections.
  assign bounce_sum = {1'b0, bounce_cnt} + {3'b000, refl_x} + {3'b000, refl_y};

  always_ff @(posedge clk) begin
    if (rst) begin
      bounce_cnt <= '0;
      step       <= STEP_W'(STEP);
    end else if (state == UPDATE) begin
      if (lost_next) begin
        bounce_cnt <= '0;
        step       <= STEP_W'(STEP);
      end else begin
        bounce_cnt <= bounce_sum[2:0];
        if (bounce_sum[3] && step != 2'd3) step <= step + 2'd1;
      end
    end
  end
`else
  assign step = STEP_W'(STEP);
`endif

endmodule

// File: tb/tb_ball_motion.sv
// ---------------------------------------------------------------------------
// tb_ball_motion
// Self-checking bench for ball_motion: directed serve/reflect cases, then
// randomized frames against a frame-level reference model, then a drain
// phase that runs the ball out of the bottom to exercise loss and re-serve.
// ---------------------------------------------------------------------------
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_pulse;
  logic       in_ball_top, in_ball_bottom, in_ball_left, in_ball_right;
  logic       solid;
  logic       launch;
  logic [9:0] x;
  logic [8:0] y;
  logic       dir_x, dir_y, moving, lost;

  int n_checks = 0;
  int n_errors = 0;
  int lost_seen = 0;

  // Reference ball, updated once per frame.
  int m_x, m_y, m_dx, m_dy;
  bit m_lost;

  localparam int START_X = 318, START_Y = 300;
  localparam int X_MIN = 8, X_MAX = 627, Y_MIN = 8, LOST_Y = 475;

  ball_motion dut (
    .clk(clk), .rst(rst), .frame_pulse(frame_pulse),
    .in_ball_top(in_ball_top), .in_ball_bottom(in_ball_bottom),
    .in_ball_left(in_ball_left), .in_ball_right(in_ball_right),
    .solid(solid), .launch(launch),
    .x(x), .y(y), .dir_x(dir_x), .dir_y(dir_y),
    .moving(moving), .lost(lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // e = {top, bottom, left, right}
  task automatic drive(input logic [3:0] e, input logic s);
    in_ball_top    = e[3];
    in_ball_bottom = e[2];
    in_ball_left   = e[1];
    in_ball_right  = e[0];
    solid          = s;
  endtask

  function automatic logic [3:0] rand_edges();
    logic [3:0] e;
    for (int b = 0; b < 4; b++) e[b] = ($urandom_range(0, 5) == 0);
    return e;
  endfunction

  task automatic model_reset();
    m_x = START_X; m_y = START_Y; m_dx = 1; m_dy = 0;
  endtask

  // Frame update from the behavioural rules, using accumulated hits h.
  task automatic model_frame(input logic [3:0] h);
    int ndx, ndy;
    ndx = m_dx; ndy = m_dy;
    if (h[1] && m_dx == 0)      ndx = 1;
    else if (h[0] && m_dx == 1) ndx = 0;
    if (h[3] && m_dy == 0)      ndy = 1;
    else if (h[2] && m_dy == 1) ndy = 0;
    if (m_x <= X_MIN)      ndx = 1;
    else if (m_x >= X_MAX) ndx = 0;
    if (m_y <= Y_MIN)      ndy = 1;
    m_x  = (ndx == 1) ? m_x + 1 : m_x - 1;
    m_y  = (ndy == 1) ? m_y + 1 : m_y - 1;
    m_dx = ndx; m_dy = ndy;
    m_lost = (m_y >= LOST_Y);
    if (m_lost) model_reset();
  endtask

  task automatic check_ball(input string tag);
    check({tag, ".x"},     int'(x),     m_x);
    check({tag, ".y"},     int'(y),     m_y);
    check({tag, ".dir_x"}, int'(dir_x), m_dx);
    check({tag, ".dir_y"}, int'(dir_y), m_dy);
  endtask

  // Idle behaviour after a loss, then serve again.
  task automatic idle_and_serve();
    drive(4'b0000, 1'b0);
    frame_pulse = 1'b0;
    launch = 1'b0;
    tick();
    check("lost_pulse_end", int'(lost), 0);
    check("idle_moving", int'(moving), 0);
    frame_pulse = 1'b1; tick();
    frame_pulse = 1'b0; tick(); tick();
    check("idle_hold_x", int'(x), START_X);
    check("idle_hold_y", int'(y), START_Y);
    check("idle_still", int'(moving), 0);
    launch = 1'b1; tick();
    launch = 1'b0;
    check("reserve_moving", int'(moving), 1);
  endtask

  // One frame: some PLAY cycles, the frame_pulse cycle, then the UPDATE
  // cycle. rnd selects random edges; otherwise pre_e is applied on the first
  // PLAY cycle and fp_e on the frame_pulse cycle, both with solid=1.
  task automatic do_frame(input bit rnd, input logic [3:0] pre_e,
                          input logic [3:0] fp_e, input bool_chk);
    logic [3:0] acc = 4'b0000;
    logic [3:0] e;
    logic       s;
    int len = rnd ? $urandom_range(1, 8) : 2;
    for (int i = 0; i < len; i++) begin
      e = rnd ? rand_edges() : ((i == 0) ? pre_e : 4'b0000);
      s = rnd ? logic'($urandom_range(0, 1)) : 1'b1;
      launch = rnd ? logic'($urandom_range(0, 1)) : 1'b0;
      drive(e, s);
      if (s) acc |= e;
      tick();
    end
    e = rnd ? rand_edges() : fp_e;
    s = rnd ? logic'($urandom_range(0, 1)) : 1'b1;
    drive(e, s);
    if (s) acc |= e;
    frame_pulse = 1'b1;
    tick();
    frame_pulse = 1'b0;
    if (bool_chk) begin
      check("update_moving", int'(moving), 1);
      check("update_no_lost", int'(lost), 0);
    end
    // Edges during UPDATE must not leak into the next frame.
    drive(rnd ? rand_edges() : 4'b0000, rnd ? logic'($urandom_range(0, 1)) : 1'b0);
    launch = 1'b0;
    tick();
    model_frame(acc);
    if (bool_chk) begin
      check_ball("frame");
      check("frame_lost", int'(lost), int'(m_lost));
      check("frame_moving", int'(moving), int'(!m_lost));
    end
    if (m_lost) begin
      lost_seen++;
      idle_and_serve();
    end
  endtask

  initial begin
    rst = 1'b1; frame_pulse = 1'b0; launch = 1'b0;
    drive(4'b0000, 1'b0);
    tick(); tick();
    rst = 1'b0;
    model_reset();
    m_lost = 1'b0;
    check_ball("reset");
    check("reset_moving", int'(moving), 0);
    check("reset_lost", int'(lost), 0);

    // frame_pulse at rest does nothing.
    frame_pulse = 1'b1; tick();
    frame_pulse = 1'b0; tick(); tick();
    check("idle_fp_x", int'(x), START_X);
    check("idle_fp_y", int'(y), START_Y);
    check("idle_fp_moving", int'(moving), 0);

    launch = 1'b1; tick();
    launch = 1'b0;
    check("launch_moving", int'(moving), 1);

    // Serve, plain step.
    do_frame(1'b0, 4'b0000, 4'b0000, 1'b1);
    check("serve_x", int'(x), 319);
    check("serve_y", int'(y), 299);
    // Top hit while moving up reflects down.
    do_frame(1'b0, 4'b1000, 4'b0000, 1'b1);
    check("top_dir_y", int'(dir_y), 1);
    check("top_y", int'(y), 300);
    // Top hit while already moving down is ignored.
    do_frame(1'b0, 4'b1000, 4'b0000, 1'b1);
    check("top_nostick_y", int'(y), 301);
    // Right hit on the frame_pulse cycle still counts.
    do_frame(1'b0, 4'b0000, 4'b0001, 1'b1);
    check("right_dir_x", int'(dir_x), 0);
    check("right_x", int'(x), 320);
    // Cleared flags: no hits next frame, ball keeps going.
    do_frame(1'b0, 4'b0000, 4'b0000, 1'b1);
    check("cleared_x", int'(x), 319);

    for (int f = 0; f < 300; f++) do_frame(1'b1, 4'b0000, 4'b0000, 1'b1);

    // Drain: no hits until the ball falls out the bottom.
    begin
      int budget = 1200;
      int seen0 = lost_seen;
      while (lost_seen == seen0 && budget > 0) begin
        do_frame(1'b0, 4'b0000, 4'b0000, 1'b1);
        budget--;
      end
      check("drain_lost_reached", int'(lost_seen > seen0), 1);
    end

    for (int f = 0; f < 20; f++) do_frame(1'b1, 4'b0000, 4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
